// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Back end of the execute stage. Pass-through ops (ALU, LUI, AUIPC, JAL,
//   JALR, word ops) write back alu_out one cycle after acceptance. Loads and
//   stores go through a single outstanding request on a doubleword-wide
//   memory port. A cycle counter aborts an access that stays outstanding for
//   too long.
//
//   Ports
//     clk, rst          rising-edge clock, synchronous active-high reset
//     in_valid/in_ready execute-stage handshake
//     opcode, func3     instr[6:2], instr[14:12]
//     alu_out           ALU result / effective address
//     store_data, rd    rs2 value, destination register
//     mem_*             request/grant + read-data memory port
//     wb_*              writeback strobe, register and value
//     exc_misaligned    pulse: access offset not a multiple of its size
//     exc_timeout       pulse: access aborted after TIMEOUT cycles
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [63:0] alu_out,
    input  logic [63:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_timeout
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         ld_off;
    logic [1:0]         ld_size;
    logic               ld_unsigned;
    logic [4:0]         pend_rd;

    // ---------------- operation decode ----------------
    logic       accept, is_load, is_store, is_pass, ld_nop, mem_op, misaligned;
    logic [1:0] size;
    logic [2:0] off;
    logic [7:0] size_mask;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign is_load  = (opcode == 5'b00000);
    assign is_store = (opcode == 5'b01000);
    assign is_pass  = opcode inside {5'b01100, 5'b00100, 5'b01101, 5'b00101,
                                     5'b11011, 5'b11001, 5'b00110, 5'b01110};
    assign ld_nop   = is_load && (func3 == 3'b111);
    // Store func3 1xx and load func3 111 never touch memory.
    assign mem_op   = (is_load && !ld_nop) || (is_store && !func3[2]);
    assign size     = func3[1:0];
    assign off      = alu_out[2:0];

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        size_mask  = 8'h01;
        misaligned = 1'b0;
        case (size)
            2'd0: begin size_mask = 8'h01; misaligned = 1'b0;            end
            2'd1: begin size_mask = 8'h03; misaligned = off[0];          end
            2'd2: begin size_mask = 8'h0F; misaligned = (off[1:0] != 0); end
            2'd3: begin size_mask = 8'hFF; misaligned = (off != 3'd0);   end
        endcase
    end

    // ---------------- load data extraction ----------------
    logic [63:0] ld_shifted, ld_data;
    assign ld_shifted = mem_rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = ld_shifted;
        case (ld_size)
            2'd0: ld_data = {{56{ld_shifted[7]  & ~ld_unsigned}}, ld_shifted[7:0]};
            2'd1: ld_data = {{48{ld_shifted[15] & ~ld_unsigned}}, ld_shifted[15:0]};
            2'd2: ld_data = {{32{ld_shifted[31] & ~ld_unsigned}}, ld_shifted[31:0]};
            2'd3: ld_data = ld_shifted;
        endcase
    end

    // ---------------- FSM and registered outputs ----------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            ld_off         <= '0;
            ld_size        <= '0;
            ld_unsigned    <= 1'b0;
            pend_rd        <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            exc_misaligned <= 1'b0;
            exc_timeout    <= 1'b0;
        end else begin
            // Pulses default low; at most one path below raises one of them.
            wb_valid       <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_timeout    <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_pass || ld_nop) begin
                            wb_valid <= (rd != 5'd0);
                            wb_rd    <= rd;
                            wb_data  <= is_pass ? alu_out : 64'd0;
                        end else if (mem_op && misaligned) begin
                            exc_misaligned <= 1'b1;
                        end else if (mem_op) begin
                            state       <= REQ;
                            cnt         <= '0;
                            mem_req     <= 1'b1;
                            mem_we      <= is_store;
                            mem_addr    <= {alu_out[63:3], 3'b000};
                            mem_wstrb   <= size_mask << off;
                            mem_wdata   <= is_store ? (store_data << {off, 3'b000}) : 64'd0;
                            ld_off      <= off;
                            ld_size     <= size;
                            ld_unsigned <= func3[2];
                            pend_rd     <= rd;
                        end
                    end
                end

                REQ, WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(TIMEOUT)) begin
                        // Abort wins over a grant or data arriving this cycle.
                        exc_timeout <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= IDLE;
                    end else if (state == REQ) begin
                        // mem_rvalid is not looked at here, even alongside a grant.
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            state   <= mem_we ? IDLE : WAIT;
                        end
                    end else if (mem_rvalid) begin
                        state    <= IDLE;
                        wb_valid <= (pend_rd != 5'd0);
                        wb_rd    <= pend_rd;
                        wb_data  <= ld_data;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed self-checking bench for load_store_unit (TIMEOUT = 4).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [63:0] alu_out;
    logic [63:0] store_data;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        exc_misaligned;
    logic        exc_timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .opcode         (opcode),
        .func3          (func3),
        .alu_out        (alu_out),
        .store_data     (store_data),
        .rd             (rd),
        .mem_req        (mem_req),
        .mem_gnt        (mem_gnt),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .exc_misaligned (exc_misaligned),
        .exc_timeout    (exc_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd,
                         input logic [4:0] r);
        in_valid   = 1'b1;
        opcode     = op;
        func3      = f3;
        alu_out    = a;
        store_data = sd;
        rd         = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; opcode = '0; func3 = '0; alu_out = '0;
        store_data = '0; rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests_run++; if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata} !== '0) begin tests_failed++; $display("FAIL reset_mem_outputs got req=%b we=%b strb=%h addr=%h wdata=%h want all zero", mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata); end
        tests_run++; if ({wb_valid, wb_rd, wb_data, exc_misaligned, exc_timeout} !== '0) begin tests_failed++; $display("FAIL reset_wb_exc got wbv=%b rd=%0d data=%h mis=%b to=%b want all zero", wb_valid, wb_rd, wb_data, exc_misaligned, exc_timeout); end
        rst = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_passthrough();
        issue(5'b01100, 3'b000, 64'h1234, 64'h0, 5'd5);       // ADD
        tick(); in_valid = 1'b0;
        tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd5, 64'h1234}) begin tests_failed++; $display("FAIL add_wb got v=%b rd=%0d data=%h want v=1 rd=5 data=1234", wb_valid, wb_rd, wb_data); end
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL add_no_mem got %b want 0", mem_req); end
        tick();
        tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL add_wb_pulse got %b want 0", wb_valid); end
        issue(5'b01100, 3'b000, 64'h77, 64'h0, 5'd0);         // rd=0 suppresses
        tick(); in_valid = 1'b0;
        tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL rd0_suppress got %b want 0", wb_valid); end
        issue(5'b11000, 3'b000, 64'h99, 64'h0, 5'd4);         // branch
        tick(); in_valid = 1'b0;
        tests_run++; if ({wb_valid, mem_req, in_ready} !== 3'b001) begin tests_failed++; $display("FAIL branch_no_wb got wbv=%b req=%b rdy=%b want 0 0 1", wb_valid, mem_req, in_ready); end
        issue(5'b01000, 3'b100, 64'h2000, 64'h5, 5'd4);       // store func3 1xx
        tick(); in_valid = 1'b0;
        tests_run++; if ({wb_valid, mem_req, in_ready} !== 3'b001) begin tests_failed++; $display("FAIL store_nop got wbv=%b req=%b rdy=%b want 0 0 1", wb_valid, mem_req, in_ready); end
        issue(5'b00000, 3'b111, 64'h2008, 64'h0, 5'd6);       // load func3 111
        tick(); in_valid = 1'b0;
        tests_run++; if ({wb_valid, wb_rd, wb_data, mem_req} !== {1'b1, 5'd6, 64'h0, 1'b0}) begin tests_failed++; $display("FAIL load111 got v=%b rd=%0d data=%h req=%b want v=1 rd=6 data=0 req=0", wb_valid, wb_rd, wb_data, mem_req); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(5'b00100, 3'b110, 64'h55, 64'h0, 5'd1);         // ORI
        tick();
        tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd1, 64'h55}) begin tests_failed++; $display("FAIL b2b_first got v=%b rd=%0d data=%h want v=1 rd=1 data=55", wb_valid, wb_rd, wb_data); end
        issue(5'b01101, 3'b000, 64'h66000, 64'h0, 5'd2);      // LUI
        tick(); in_valid = 1'b0;
        tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd2, 64'h66000}) begin tests_failed++; $display("FAIL b2b_second got v=%b rd=%0d data=%h want v=1 rd=2 data=66000", wb_valid, wb_rd, wb_data); end
        tick();
    endtask

    task automatic test_lb();
        issue(5'b00000, 3'b000, 64'h1003, 64'h0, 5'd7);
        tick(); in_valid = 1'b0;
        tests_run++; if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 64'h1000, 8'h08}) begin tests_failed++; $display("FAIL lb_req got req=%b we=%b addr=%h strb=%h want 1 0 1000 08", mem_req, mem_we, mem_addr, mem_wstrb); end
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        tests_run++; if ({mem_req, in_ready} !== 2'b00) begin tests_failed++; $display("FAIL lb_wait got req=%b rdy=%b want 0 0", mem_req, in_ready); end
        mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_8000_0000;
        tick(); mem_rvalid = 1'b0;
        tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80}) begin tests_failed++; $display("FAIL lb_wb got v=%b rd=%0d data=%h want v=1 rd=7 data=ffffffffffffff80", wb_valid, wb_rd, wb_data); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL lb_idle got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_lhu_gnt_rvalid();
        issue(5'b00000, 3'b101, 64'h6006, 64'h0, 5'd8);
        tick(); in_valid = 1'b0;
        tests_run++; if ({mem_req, mem_addr, mem_wstrb} !== {1'b1, 64'h6000, 8'hC0}) begin tests_failed++; $display("FAIL lhu_req got req=%b addr=%h strb=%h want 1 6000 c0", mem_req, mem_addr, mem_wstrb); end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tests_run++; if ({wb_valid, in_ready, mem_req} !== 3'b000) begin tests_failed++; $display("FAIL gnt_rvalid_ignored got wbv=%b rdy=%b req=%b want 0 0 0", wb_valid, in_ready, mem_req); end
        tick();
        tests_run++; if ({wb_valid, in_ready} !== 2'b00) begin tests_failed++; $display("FAIL lhu_still_wait got wbv=%b rdy=%b want 0 0", wb_valid, in_ready); end
        mem_rvalid = 1'b1; mem_rdata = 64'h8001_0000_0000_0000;
        tick(); mem_rvalid = 1'b0;
        tests_run++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd8, 64'h8001}) begin tests_failed++; $display("FAIL lhu_wb got v=%b rd=%0d data=%h want v=1 rd=8 data=8001", wb_valid, wb_rd, wb_data); end
        tick();
    endtask

    task automatic test_sh_delayed();
        int req_cycles = 0;
        int wb_seen    = 0;
        issue(5'b01000, 3'b001, 64'h2006, 64'hABCD, 5'd3);
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (wb_valid === 1'b1) wb_seen++;
            tests_run++; if ({mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 64'h2000, 8'hC0, 64'hABCD_0000_0000_0000}) begin tests_failed++; $display("FAIL sh_stable cyc=%0d got we=%b addr=%h strb=%h wdata=%h want 1 2000 c0 abcd000000000000", i, mem_we, mem_addr, mem_wstrb, mem_wdata); end
            if (i == 3) mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        if (wb_valid === 1'b1) wb_seen++;
        tests_run++; if (req_cycles !== 4) begin tests_failed++; $display("FAIL sh_req_cycles got %0d want 4", req_cycles); end
        tests_run++; if ({mem_req, in_ready} !== 2'b01) begin tests_failed++; $display("FAIL sh_done got req=%b rdy=%b want 0 1", mem_req, in_ready); end
        tick();
        if (wb_valid === 1'b1) wb_seen++;
        tests_run++; if (wb_seen !== 0) begin tests_failed++; $display("FAIL sh_no_wb got %0d wb pulses want 0", wb_seen); end
    endtask

    task automatic test_misaligned();
        issue(5'b00000, 3'b010, 64'h3002, 64'h0, 5'd9);
        tick(); in_valid = 1'b0;
        tests_run++; if ({exc_misaligned, mem_req, wb_valid, in_ready} !== 4'b1001) begin tests_failed++; $display("FAIL lw_misaligned got mis=%b req=%b wbv=%b rdy=%b want 1 0 0 1", exc_misaligned, mem_req, wb_valid, in_ready); end
        tick();
        tests_run++; if ({exc_misaligned, mem_req, in_ready} !== 3'b001) begin tests_failed++; $display("FAIL lw_mis_pulse got mis=%b req=%b rdy=%b want 0 0 1", exc_misaligned, mem_req, in_ready); end
        issue(5'b01000, 3'b011, 64'h3004, 64'h1, 5'd0);       // SD at offset 4
        tick(); in_valid = 1'b0;
        tests_run++; if ({exc_misaligned, mem_req} !== 2'b10) begin tests_failed++; $display("FAIL sd_misaligned got mis=%b req=%b want 1 0", exc_misaligned, mem_req); end
        tick();
    endtask

    task automatic test_timeout();
        int cyc = 0;
        int wb_seen = 0;
        issue(5'b00000, 3'b011, 64'h4000, 64'h0, 5'd3);
        tick(); in_valid = 1'b0;
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0; cyc = 1;
        while (exc_timeout !== 1'b1 && cyc < 20) begin
            if (wb_valid === 1'b1) wb_seen++;
            tick(); cyc++;
        end
        tests_run++; if (cyc !== 5) begin tests_failed++; $display("FAIL ld_timeout_cycle got %0d want 5", cyc); end
        tests_run++; if ({exc_timeout, wb_valid, mem_req, in_ready} !== 4'b1001) begin tests_failed++; $display("FAIL ld_timeout_pulse got to=%b wbv=%b req=%b rdy=%b want 1 0 0 1", exc_timeout, wb_valid, mem_req, in_ready); end
        tick();
        tests_run++; if ({exc_timeout, wb_valid, in_ready} !== 3'b001) begin tests_failed++; $display("FAIL ld_timeout_after got to=%b wbv=%b rdy=%b want 0 0 1", exc_timeout, wb_valid, in_ready); end
        tests_run++; if (wb_seen !== 0) begin tests_failed++; $display("FAIL ld_timeout_no_wb got %0d want 0", wb_seen); end
    endtask

    task automatic test_wait_reset();
        issue(5'b00000, 3'b011, 64'h5008, 64'h0, 5'd9);
        tick(); in_valid = 1'b0;
        mem_gnt = 1'b1;
        tick(); mem_gnt = 1'b0;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_wait_busy got %b want 0", in_ready); end
        rst = 1'b1;
        tick();
        tests_run++; if ({mem_req, mem_addr, mem_wstrb, wb_valid, exc_timeout, exc_misaligned, in_ready} !== '0) begin tests_failed++; $display("FAIL rst_wait_zero got req=%b addr=%h strb=%h wbv=%b to=%b mis=%b rdy=%b want zeros", mem_req, mem_addr, mem_wstrb, wb_valid, exc_timeout, exc_misaligned, in_ready); end
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_wait_ready got %b want 1", in_ready); end
        tick(); mem_rvalid = 1'b0;
        tests_run++; if ({wb_valid, exc_timeout, in_ready} !== 3'b001) begin tests_failed++; $display("FAIL rst_late_rvalid got wbv=%b to=%b rdy=%b want 0 0 1", wb_valid, exc_timeout, in_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_lb();
        test_lhu_gnt_rvalid();
        test_sh_delayed();
        test_misaligned();
        test_timeout();
        test_wait_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 255, the maximum number of cycles a memory access may remain outstanding before it is aborted.
REQ-002 The block SHALL provide the following ports:
  clk             in   1   clock; all logic rising-edge
  rst             in   1   synchronous reset, active-high
  in_valid        in   1   execute-stage result valid
  in_ready        out  1   unit can accept an operation this cycle
  opcode          in   5   instr[6:2]
  func3           in   3   instr[14:12]
  alu_out         in   64  ALU result / effective address
  store_data      in   64  rs2 value
  rd              in   5   destination register
  mem_req         out  1   memory request
  mem_gnt         in   1   memory accepted request
  mem_we          out  1   1 = store
  mem_addr        out  64  doubleword-aligned address
  mem_wdata       out  64  lane-shifted store data
  mem_wstrb       out  8   byte enables
  mem_rvalid      in   1   read data valid
  mem_rdata       in   64  read doubleword
  wb_valid        out  1   writeback strobe
  wb_rd           out  5   writeback register
  wb_data         out  64  writeback value
  exc_misaligned  out  1   misaligned-access pulse
  exc_timeout     out  1   access-timeout pulse

Function
REQ-003 The block SHALL accept an operation only when in_valid and in_ready are both 1; in_ready SHALL equal (state==IDLE) and not rst.
REQ-004 The FSM SHALL have three states, IDLE, REQ and WAIT, with these transitions: IDLE->REQ on an accepted, aligned load or store; REQ->WAIT on mem_gnt for a load; REQ->IDLE on mem_gnt for a store; WAIT->IDLE on mem_rvalid.
REQ-005 The block SHALL treat opcodes 01100, 00100, 01101, 00101, 11011, 11001, 00110 and 01110 as pass-through: wb_valid=1 one cycle after acceptance, with wb_data=alu_out and wb_rd=rd; there SHALL be no memory access.
REQ-006 For opcodes 11000 (branch) and 01000 (store), and for any other opcode, the block SHALL NOT assert wb_valid.
REQ-007 Load func3 encodings SHALL be: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Load func3 111 SHALL produce no access, wb_valid=1 and wb_data=0.
REQ-008 Store func3 encodings SHALL be: 000 SB, 001 SH, 010 SW, 011 SD. Store func3 1xx SHALL be a no-op with no access.
REQ-009 The block SHALL take the offset as alu_out[2:0] and drive mem_addr={alu_out[63:3],3'b000}.
REQ-010 An access whose offset is not a multiple of its size SHALL cause exc_misaligned=1 for exactly one cycle after acceptance, with no mem_req and no wb_valid; the FSM SHALL stay in IDLE.
REQ-011 The block SHALL drive mem_wstrb=(size mask)<<offset and mem_wdata=store_data<<(8*offset); for loads mem_wstrb SHALL be the same mask and mem_we=0.
REQ-012 The block SHALL assert mem_req in the cycle after acceptance and hold it until mem_gnt; mem_addr, mem_we, mem_wdata and mem_wstrb SHALL remain stable while mem_req=1.
REQ-013 The block SHALL extract load data as mem_rdata>>(8*offset), truncate it to the access size, sign-extend it for LB/LH/LW and zero-extend it for LBU/LHU/LWU.
REQ-014 The extracted load data SHALL appear on wb_data with wb_valid=1 in the cycle after mem_rvalid, and the FSM SHALL be in IDLE that same cycle.
REQ-015 When rd==0, wb_valid SHALL be suppressed for all operations.
REQ-016 mem_rvalid SHALL be ignored outside WAIT.
REQ-017 If mem_gnt and mem_rvalid arrive in the same cycle while in REQ, the block SHALL ignore mem_rvalid and move to WAIT.
REQ-018 A cycle counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-019 When the counter reaches TIMEOUT, the block SHALL pulse exc_timeout for one cycle, deassert mem_req, return to IDLE and issue no wb_valid.
REQ-020 wb_valid, exc_misaligned and exc_timeout SHALL each be single-cycle registered pulses.
REQ-021 Outputs wb_valid, exc_misaligned and exc_timeout SHALL be mutually exclusive in any cycle.

Reset
REQ-022 While rst=1 at a clock edge: state SHALL become IDLE; the counter SHALL be 0; mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, exc_misaligned and exc_timeout SHALL be 0.
REQ-023 A reset asserted mid-access SHALL abandon the access with no wb_valid or exception pulse; in_ready SHALL be 1 in the first cycle after rst falls.

Verification
REQ-024 ADD pass-through (opcode 01100, alu_out=0x1234, rd=5) -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234.
REQ-025 LB with alu_out=0x1003 and mem_rdata=0x0000_0000_8000_0000 -> mem_addr=0x1000, mem_wstrb=0x08; after rvalid, wb_data=0xFFFF_FFFF_FFFF_FF80.
REQ-026 SH with alu_out=0x2006, store_data=0xABCD, mem_gnt delayed 3 cycles -> mem_req held 4 cycles, mem_wstrb=0xC0, mem_wdata=0xABCD<<48, no wb_valid.
REQ-027 LW with alu_out=0x3002 -> exc_misaligned pulse, mem_req never 1, in_ready stays 1.
REQ-028 LD with mem_gnt=1 but mem_rvalid never asserted, TIMEOUT=4 -> exc_timeout pulse, then in_ready=1 and no wb_valid.
REQ-029 rst asserted while in WAIT, then a late mem_rvalid -> no wb_valid, outputs zero, and in_ready=1 after rst falls.
